// File: rtl/mcpu_core_issue_ctl_pkg.sv
// Shared definitions for the issue controller: packet geometry, FSM states
// and the held-packet record.
package mcpu_core_issue_ctl_pkg;

   localparam int LANES          = 4;
   localparam int REG_W          = 5;
   localparam int NUM_PRED       = 3;
   localparam int PRED_W         = 2;
   localparam logic [PRED_W-1:0] PRED_UNGUARDED = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_DRAIN = 2'd2
   } is_state_e;

   typedef struct packed {
      logic [LANES*REG_W-1:0]  rs_num;
      logic [LANES*REG_W-1:0]  rt_num;
      logic [LANES-1:0]        rs_use;
      logic [LANES-1:0]        rt_use;
      logic [LANES*REG_W-1:0]  rd_num;
      logic [LANES-1:0]        rd_we;
      logic [LANES-1:0]        pred_we;
      logic [LANES*PRED_W-1:0] pred_num;
   } is_pkt_t;

   // Keep register numbers but drop every enable, so a discarded packet
   // can neither hazard nor be mistaken for live write enables downstream.
   function automatic is_pkt_t pkt_drop_enables(input is_pkt_t p);
      is_pkt_t r;
      r         = p;
      r.rs_use  = '0;
      r.rt_use  = '0;
      r.rd_we   = '0;
      r.pred_we = '0;
      return r;
   endfunction

endpackage

// File: rtl/mcpu_core_issue_hazard.sv
// Per-lane operand hazard check against the register/predicate scoreboard.
// Purely combinational; one instance per lane, OR-reduced by the parent.
module mcpu_core_issue_hazard
   import mcpu_core_issue_ctl_pkg::*;
#(
   parameter bit CHECK_WAW = 1'b1
) (
   input  logic [REG_W-1:0]    rs_num_i,
   input  logic [REG_W-1:0]    rt_num_i,
   input  logic                rs_use_i,
   input  logic                rt_use_i,
   input  logic [REG_W-1:0]    rd_num_i,
   input  logic                rd_we_i,
   input  logic                pred_we_i,
   input  logic [PRED_W-1:0]   pred_num_i,
   input  logic [31:0]         reg_sb_i,
   input  logic [NUM_PRED-1:0] pred_sb_i,
   output logic                hazard_o
);

   // Padded so the unguarded code (3) indexes a constant zero slot.
   logic [(1<<PRED_W)-1:0] pred_sb_ext;
   logic src_hz;
   logic guard_hz;
   logic waw_reg_hz;
   logic waw_pred_hz;

   assign pred_sb_ext = {{((1<<PRED_W)-NUM_PRED){1'b0}}, pred_sb_i};

   assign src_hz   = (rs_use_i & reg_sb_i[rs_num_i]) | (rt_use_i & reg_sb_i[rt_num_i]);
   assign guard_hz = (pred_num_i != PRED_UNGUARDED) & pred_sb_ext[pred_num_i];

   // Predicate destinations beyond the last predicate are illegal and masked.
   assign waw_reg_hz  = rd_we_i & reg_sb_i[rd_num_i];
   assign waw_pred_hz = pred_we_i & (rd_num_i < REG_W'(NUM_PRED)) & pred_sb_ext[rd_num_i[1:0]];

   assign hazard_o = src_hz | guard_hz | (CHECK_WAW ? (waw_reg_hz | waw_pred_hz) : 1'b0);

endmodule

// File: rtl/mcpu_core_issue_ctl.sv
// Issue controller: holds one decoded 4-lane packet, checks it against the
// scoreboard and strobes progress when it may commit. Serializing packets
// wait for a fully clear scoreboard; flush discards the held packet.
module mcpu_core_issue_ctl
   import mcpu_core_issue_ctl_pkg::*;
#(
   parameter int STALL_CNT_W = 16,
   parameter bit CHECK_WAW   = 1'b1
) (
   input  logic                      clkrst_core_clk,
   input  logic                      clkrst_core_rst,
   input  logic                      d2is_valid,
   output logic                      d2is_ready,
   input  logic [LANES*REG_W-1:0]    d2is_rs_num,
   input  logic [LANES*REG_W-1:0]    d2is_rt_num,
   input  logic [LANES-1:0]          d2is_rs_use,
   input  logic [LANES-1:0]          d2is_rt_use,
   input  logic [LANES*REG_W-1:0]    d2is_rd_num,
   input  logic [LANES-1:0]          d2is_rd_we,
   input  logic [LANES-1:0]          d2is_pred_we,
   input  logic [LANES*PRED_W-1:0]   d2is_pred_num,
   input  logic                      d2is_serialize,
   input  logic                      flush,
   input  logic [31:0]               sb2d_reg_scoreboard,
   input  logic [NUM_PRED-1:0]       sb2d_pred_scoreboard,
   output logic                      d2pc_progress,
   output logic [LANES*REG_W-1:0]    d2pc_out_rd_num,
   output logic [LANES-1:0]          d2pc_out_rd_we,
   output logic [LANES-1:0]          d2pc_out_pred_we,
   output logic [STALL_CNT_W-1:0]    is_stall_cnt,
   output logic [1:0]                is_state
);

   is_state_e              state_q, state_d;
   is_pkt_t                pkt_q, pkt_d, pkt_in;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [LANES-1:0]       lane_hz;
   logic                   hazard;
   logic                   sb_clear;
   logic                   stall_cycle;

   assign pkt_in = '{rs_num:  d2is_rs_num,  rt_num:  d2is_rt_num,
                     rs_use:  d2is_rs_use,  rt_use:  d2is_rt_use,
                     rd_num:  d2is_rd_num,  rd_we:   d2is_rd_we,
                     pred_we: d2is_pred_we, pred_num: d2is_pred_num};

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         mcpu_core_issue_hazard #(.CHECK_WAW(CHECK_WAW)) u_hazard (
            .rs_num_i   (pkt_q.rs_num[gi*REG_W +: REG_W]),
            .rt_num_i   (pkt_q.rt_num[gi*REG_W +: REG_W]),
            .rs_use_i   (pkt_q.rs_use[gi]),
            .rt_use_i   (pkt_q.rt_use[gi]),
            .rd_num_i   (pkt_q.rd_num[gi*REG_W +: REG_W]),
            .rd_we_i    (pkt_q.rd_we[gi]),
            .pred_we_i  (pkt_q.pred_we[gi]),
            .pred_num_i (pkt_q.pred_num[gi*PRED_W +: PRED_W]),
            .reg_sb_i   (sb2d_reg_scoreboard),
            .pred_sb_i  (sb2d_pred_scoreboard),
            .hazard_o   (lane_hz[gi])
         );
      end
   endgenerate

   assign hazard   = |lane_hz;
   assign sb_clear = (sb2d_reg_scoreboard == '0) && (sb2d_pred_scoreboard == '0);

   // Next-state, packet load/discard and handshake decode.
   always_comb begin
      state_d       = state_q;
      pkt_d         = pkt_q;
      d2pc_progress = 1'b0;
      d2is_ready    = 1'b0;
      stall_cycle   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            d2is_ready = 1'b1;
            if (d2is_valid) begin
               pkt_d   = pkt_in;
               state_d = d2is_serialize ? ST_DRAIN : ST_HOLD;
            end
         end
         ST_HOLD, ST_DRAIN: begin
            d2pc_progress = ~flush & ((state_q == ST_HOLD) ? ~hazard : sb_clear);
            // Ready follows progress so the next packet loads on the issue edge.
            d2is_ready    = d2pc_progress;
            stall_cycle   = ~d2pc_progress;
            if (d2pc_progress && d2is_valid) begin
               pkt_d   = pkt_in;
               state_d = d2is_serialize ? ST_DRAIN : ST_HOLD;
            end else if (d2pc_progress || flush) begin
               pkt_d   = pkt_drop_enables(pkt_q);
               state_d = ST_IDLE;
            end
         end
         default: begin
            pkt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   assign stall_cnt_d = (stall_cycle && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;

   // FSM state and held packet registers.
   always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
      if (clkrst_core_rst) begin
         state_q <= ST_IDLE;
         pkt_q   <= '0;
      end else begin
         state_q <= state_d;
         pkt_q   <= pkt_d;
      end
   end

   // Saturating stall-cycle counter, cleared only by reset.
   always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
      if (clkrst_core_rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign d2pc_out_rd_num  = pkt_q.rd_num;
   assign d2pc_out_rd_we   = pkt_q.rd_we;
   assign d2pc_out_pred_we = pkt_q.pred_we;
   assign is_stall_cnt     = stall_cnt_q;
   assign is_state         = state_q;

endmodule
